// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr} pairs between fetch and decode.
// Optional 0-cycle empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_4,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [31:0]      pc_mem_r    [DEPTH];
  logic [31:0]      instr_mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             empty_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;

  assign empty_s  = (count_r == CNT_ZERO);
  // Full blocks pushes outright, even when a pop happens in the same cycle.
  assign in_ready = (count_r != CNT_FULL);
  assign count    = count_r;
  assign out_pc_4 = out_pc + 32'd4;

  // Head selection and handshake qualification.
  always_comb begin
    bypass_s  = 1'b0;
    out_valid = 1'b0;
    out_pc    = pc_mem_r[rd_ptr_r];
    out_instr = instr_mem_r[rd_ptr_r];
    push_s    = 1'b0;
    pop_s     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass_s  = empty_s & in_valid & ~flush;
`else
    bypass_s  = 1'b0;
`endif
    if (bypass_s) begin
      // Entry goes straight to decode; only stored if decode does not take it now.
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
      push_s    = ~out_ready;
      pop_s     = 1'b0;
    end else begin
      out_valid = ~empty_s & ~flush;
      push_s    = in_valid & in_ready & ~flush;
      pop_s     = out_valid & out_ready;
    end
  end

  // Pointer, occupancy and storage update; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'd0;
        instr_mem_r[i] <= 32'd0;
      end
    end else if (flush) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= in_pc;
        instr_mem_r[wr_ptr_r] <= in_instr;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4); bypass checks follow FETCHQ_BYPASS_EN.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total;
  int bad;

  if_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc_4(out_pc_4),
    .out_instr(out_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    total++; if (out_pc_4 !== 32'd4) begin bad++; $display("FAIL reset_out_pc_4 got=%h exp=4", out_pc_4); end
    total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(i * 4);
      in_instr = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 0) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
          bad++; $display("FAIL fill_latency got valid=%0b pc=%h exp valid=1 pc=0", out_valid, out_pc);
        end
      end
    end
    in_pc = 32'h10; in_instr = 32'hA000_0010;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_fifth_rejected got=%0d exp=4", count); end
    total++; if (out_pc !== 32'd0 || out_instr !== 32'hA000_0000) begin
      bad++; $display("FAIL fill_head_hold got pc=%h instr=%h exp pc=0 instr=a0000000", out_pc, out_instr);
    end
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_pc_4 !== 32'(i * 4 + 4)
                   || out_instr !== 32'hA000_0000 + 32'(i)) begin
        bad++; $display("FAIL drain_%0d got valid=%0b pc=%h pc4=%h instr=%h exp pc=%h", i, out_valid,
                        out_pc, out_pc_4, out_instr, 32'(i * 4));
      end
      tick();
    end
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got count=%0d valid=%0b exp count=0 valid=0", count, out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h200;
    in_instr  = 32'hB000_0000;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc    = 32'h204 + 32'(4 * k);
      in_instr = 32'hB000_0001 + 32'(k);
      #1;
      total++; if (out_pc !== 32'h200 + 32'(4 * k) || out_instr !== 32'hB000_0000 + 32'(k)) begin
        bad++; $display("FAIL wrap_order_%0d got pc=%h instr=%h exp pc=%h", k, out_pc, out_instr,
                        32'h200 + 32'(4 * k));
      end
      tick();
      total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count_%0d got=%0d exp=1", k, count); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_pc !== 32'h228) begin bad++; $display("FAIL wrap_last got=%h exp=228", out_pc); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h300 + 32'(4 * i);
      in_instr = 32'hC000_0000 + 32'(i);
      tick();
    end
    flush = 1'b1; in_pc = 32'h40; in_instr = 32'hC000_0040;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_forced got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_cleared got count=%0d valid=%0b exp 0/0", count, out_valid);
    end
    in_valid = 1'b1; in_pc = 32'h50; in_instr = 32'hC000_0050;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd1 || out_pc !== 32'h50) begin
      bad++; $display("FAIL flush_refill got count=%0d pc=%h exp count=1 pc=50", count, out_pc);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_pc4_wrap();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'hFFFF_FFFC;
    in_instr  = 32'hD000_0000;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_pc_4 !== 32'd0 || out_pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL pc4_wrap got pc=%h pc4=%h exp pc=fffffffc pc4=0", out_pc, out_pc_4);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h600 + 32'(4 * i);
      in_instr = 32'hE000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL midop_pre_count got=%0d exp=2", count); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || out_pc_4 !== 32'd4) begin
      bad++; $display("FAIL midop_reset got valid=%0b count=%0d in_ready=%0b pc4=%h exp 0/0/1/4",
                      out_valid, count, in_ready, out_pc_4);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    in_valid  = 1'b1;
    in_pc     = 32'h100;
    in_instr  = 32'hF000_0100;
    out_ready = 1'b1;
    #1;
`ifdef FETCHQ_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_pc_4 !== 32'h104) begin
      bad++; $display("FAIL bypass_same_cycle got valid=%0b pc=%h pc4=%h exp 1/100/104", out_valid, out_pc, out_pc_4);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bypass_no_store got count=%0d valid=%0b exp 0/0", count, out_valid);
    end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_same_cycle got=%0b exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 3'd1) begin
      bad++; $display("FAIL nobypass_next_cycle got valid=%0b pc=%h count=%0d exp 1/100/1", out_valid, out_pc, count);
    end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL nobypass_drain got=%0d exp=0", count); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_pc4_wrap();
    test_reset_midop();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
